// File: rtl/alu_exec_sequencer.sv
// rtl/alu_exec_sequencer.sv - execute-stage sequencer: external ALU dispatch plus iterative unsigned MULT/DIV
// Optional feature macro: ALU_SEQ_DIV0_FLAG_EN (div0 output, single-cycle divide-by-zero)
module alu_exec_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       alu_control,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
`ifdef ALU_SEQ_DIV0_FLAG_EN
  output logic             div0,
`endif
  output logic             illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, MULDIV, DONE} state_t;
  typedef enum logic [1:0] {K_ALU, K_MUL, K_DIV, K_ILL} kind_t;

  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_MOV  = 4'b0011;
  localparam logic [3:0] C_MOVI = 4'b0111;
  localparam logic [3:0] C_NONE = 4'b0000;

  state_t           state, state_next;
  kind_t            dec_kind;
  logic [3:0]       dec_code, code_q;
  logic             is_div_q;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;
  logic             skip_div;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;

  always_comb begin
    dec_kind = K_ILL;
    dec_code = C_NONE;
    case (alu_op)
      2'b00: begin dec_kind = K_ALU; dec_code = C_MOVI; end
      2'b01: begin dec_kind = K_ALU; dec_code = C_SUB;  end
      2'b10: begin
        case (funct)
          6'b100000: begin dec_kind = K_ALU; dec_code = C_ADD; end
          6'b100100: begin dec_kind = K_ALU; dec_code = C_SUB; end
          6'b100011: begin dec_kind = K_ALU; dec_code = C_MOV; end
          6'b100001: dec_kind = K_MUL;
          6'b100010: dec_kind = K_DIV;
          default:   dec_kind = K_ILL;
        endcase
      end
      default: dec_kind = K_ILL;
    endcase
  end

  // A zero divisor takes the one-cycle EXEC slot instead of the iterative path.
`ifdef ALU_SEQ_DIV0_FLAG_EN
  assign skip_div = (dec_kind == K_DIV) && (op_b == '0);
`else
  assign skip_div = 1'b0;
`endif

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Multiply: {result_hi, result_lo} is the product register, multiplier shifts out of result_lo.
  assign mul_sum   = {1'b0, result_hi} + (result_lo[0] ? {1'b0, alu_a} : '0);
  // Divide: result_hi is the partial remainder, result_lo shifts dividend out and quotient in.
  assign div_shift = {result_hi, result_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, alu_b};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    alu_control = C_NONE;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (dec_kind == K_ILL)                   state_next = DONE;
          else if (dec_kind == K_ALU || skip_div)  state_next = EXEC;
          else                                     state_next = MULDIV;
        end
      end
      EXEC: begin
        alu_control = code_q;
        state_next  = DONE;
      end
      MULDIV: if (last_iter) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      code_q    <= C_NONE;
      is_div_q  <= 1'b0;
      cnt       <= '0;
      result_lo <= '0;
      result_hi <= '0;
      illegal   <= 1'b0;
`ifdef ALU_SEQ_DIV0_FLAG_EN
      div0      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          alu_a     <= op_a;
          alu_b     <= op_b;
          code_q    <= dec_code;
          is_div_q  <= (dec_kind == K_DIV);
          cnt       <= '0;
          result_hi <= '0;
          illegal   <= (dec_kind == K_ILL);
`ifdef ALU_SEQ_DIV0_FLAG_EN
          div0      <= skip_div;
`endif
          if (dec_kind == K_MUL)      result_lo <= op_b;
          else if (dec_kind == K_DIV) result_lo <= op_a;
          else                        result_lo <= '0;
        end
        EXEC: begin
`ifdef ALU_SEQ_DIV0_FLAG_EN
          if (div0) begin
            result_lo <= '0;
            result_hi <= alu_a;
          end else begin
            result_lo <= alu_result;
            result_hi <= '0;
          end
`else
          result_lo <= alu_result;
          result_hi <= '0;
`endif
        end
        MULDIV: begin
          cnt <= last_iter ? '0 : cnt + CNT_W'(1);
          if (is_div_q) begin
            result_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            result_lo <= {result_lo[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            {result_hi, result_lo} <= {mul_sum, result_lo[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// tb/tb_alu_exec_sequencer.sv - scoreboard bench for alu_exec_sequencer with reference model and random stimulus
module tb_alu_exec_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, illegal;
  logic [1:0]   alu_op = 2'b00;
  logic [5:0]   funct = 6'd0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic [W-1:0] alu_a, alu_b, alu_result, result_lo, result_hi;
  logic [3:0]   alu_control;
`ifdef ALU_SEQ_DIV0_FLAG_EN
  logic         div0;
`endif

  alu_exec_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .result_lo(result_lo), .result_hi(result_hi),
`ifdef ALU_SEQ_DIV0_FLAG_EN
    .div0(div0),
`endif
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // External combinational ALU
  always_comb begin
    case (alu_control)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0011: alu_result = alu_a;
      4'b0111: alu_result = alu_b;
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ill;
    logic         dz;
    int           due;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          ctl_k = -1;
  logic [3:0]  ctl_code = 4'b0000;
  bit          mon_en = 0;
  bit          prev_hs = 0;
  bit          prev_valid = 0;
  int          rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1)      out_ready = 1'b0;
    else if (rdy_mode == 2) out_ready = 1'b1;
    else                    out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [5:0] fn,
                                input logic [W-1:0] a, input logic [W-1:0] b, input int k,
                                output exp_t e, output logic [3:0] code);
    logic [2*W-1:0] p;
    e.lo = '0; e.hi = '0; e.ill = 1'b0; e.dz = 1'b0; e.due = k + 1; code = 4'b0000;
    if (op == 2'b00)                        begin code = 4'b0111; e.lo = b; end
    else if (op == 2'b01)                   begin code = 4'b0110; e.lo = a - b; end
    else if (op == 2'b10 && fn == 6'b100000) begin code = 4'b0010; e.lo = a + b; end
    else if (op == 2'b10 && fn == 6'b100100) begin code = 4'b0110; e.lo = a - b; end
    else if (op == 2'b10 && fn == 6'b100011) begin code = 4'b0011; e.lo = a; end
    else if (op == 2'b10 && fn == 6'b100001) begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      e.hi = p[2*W-1:W]; e.lo = p[W-1:0]; e.due = k + W;
    end else if (op == 2'b10 && fn == 6'b100010) begin
      if (b == '0) begin
`ifdef ALU_SEQ_DIV0_FLAG_EN
        e.dz = 1'b1; e.lo = '0; e.hi = a; e.due = k + 1;
`else
        e.lo = '1; e.hi = a; e.due = k + W;
`endif
      end else begin
        e.lo = a / b; e.hi = a % b; e.due = k + W;
      end
    end else begin
      e.ill = 1'b1; e.due = k;
    end
  endfunction

  // Monitor: checks every cycle the result is presented, pops on handshake
  always @(negedge clk) begin
    if (mon_en) begin
      check("alu_control", alu_control, (cyc == ctl_k) ? ctl_code : 4'b0000);
      if (prev_hs) begin
        check("in_ready_after_handoff", in_ready, 1);
        check("out_valid_after_handoff", out_valid, 0);
      end
      if (out_valid) begin
        if (sb.size() == 0) check("out_valid_unexpected", out_valid, 0);
        else begin
          if (!prev_valid) check("latency", cyc, sb[0].due);
          check("result_lo", result_lo, sb[0].lo);
          check("result_hi", result_hi, sb[0].hi);
          check("illegal", illegal, sb[0].ill);
`ifdef ALU_SEQ_DIV0_FLAG_EN
          check("div0", div0, sb[0].dz);
`endif
          check("in_ready_while_done", in_ready, 0);
        end
      end
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
      if (prev_hs && sb.size() > 0) void'(sb.pop_front());
    end
  end

  task automatic junk();
    in_valid = 1'b1;
    alu_op   = 2'($urandom_range(0, 3));
    funct    = 6'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t       e;
    logic [3:0] code;
    int         n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      junk();
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      check("in_ready_timeout", in_ready, 1);
      return;
    end
    alu_op = op; funct = fn; op_a = a; op_b = b; in_valid = 1'b1;
    model(op, fn, a, b, cyc + 1, e, code);
    sb.push_back(e);
    ctl_k = cyc + 1;
    ctl_code = code;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fns[5];
    int         wn;
    fns[0] = 6'b100000; fns[1] = 6'b100100; fns[2] = 6'b100001; fns[3] = 6'b100010; fns[4] = 6'b100011;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_illegal", illegal, 0);
    check("reset_alu_control", alu_control, 0);
    check("reset_operands", {alu_a, alu_b}, 64'd0);
    check("reset_results", {result_hi, result_lo}, 64'd0);
    mon_en = 1;

    issue(2'b10, 6'b100000, 32'd5, 32'd7);
    issue(2'b10, 6'b100001, 32'h0001_0000, 32'h0001_0003);
    issue(2'b10, 6'b100010, 32'd100, 32'd7);
    issue(2'b10, 6'b100010, 32'hFFFF_FFFF, 32'd1);
    issue(2'b10, 6'b111111, 32'd3, 32'd4);
    issue(2'b11, 6'b100000, 32'd3, 32'd4);
    issue(2'b00, 6'b000000, 32'd0, 32'h1234_5678);
    issue(2'b01, 6'b000000, 32'd0, 32'd1);
    issue(2'b10, 6'b100010, 32'd9, 32'd0);
    drain();

    // Backpressure: result must hold, junk requests ignored
    rdy_mode = 1;
    issue(2'b10, 6'b100100, 32'd50, 32'd8);
    wn = 0;
    while (!out_valid && wn < 100) begin @(negedge clk); wn++; end
    check("bp_out_valid_seen", out_valid, 1);
    repeat (3) begin
      junk();
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    rdy_mode = 2;
    drain();
    rdy_mode = 0;

    // Reset in the middle of a MULT
    issue(2'b10, 6'b100001, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (9) @(negedge clk);
    mon_en = 0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    ctl_k = -1; prev_hs = 0; prev_valid = 0;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_in_ready", in_ready, 1);
    check("midreset_results", {result_hi, result_lo}, 64'd0);
    mon_en = 1;
    issue(2'b10, 6'b100000, 32'd1, 32'd1);
    drain();

    for (int i = 0; i < 150; i++) begin
      logic [1:0]   op;
      logic [5:0]   fn;
      logic [W-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      a  = ($urandom_range(0, 1) == 0) ? $urandom : W'($urandom_range(0, 300));
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      issue(op, fn, a, b);
    end
    drain();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
- Execute-stage controller between the ALU control decoder inputs (ALUOp, funct) and the 32-bit datapath.
- Accepts one operation per valid/ready handshake.
- Single-cycle ops (ADD/SUB/MOV/MOVI) go to the external combinational ALU through alu_control; the result is captured one cycle later.
- MULT/DIV run on an internal iterative shift-add multiplier or restoring divider over WIDTH cycles. The result is held under a valid/ready output handshake.

Parameters:
- WIDTH, 32, operand/result width in bits; also the MULT/DIV iteration count.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  sequencer can accept
- alu_op  input  2  ALUOp: 00=MOVI, 01=SUB, 10=R-type (use funct), 11=illegal
- funct  input  6  100000 ADD, 100100 SUB, 100001 MULT, 100010 DIV, 100011 MOV; anything else illegal
- op_a  input  WIDTH  source operand / dividend / multiplicand
- op_b  input  WIDTH  source operand / immediate / divisor / multiplier
- alu_control  output  4  to ALU: 0010 ADD, 0110 SUB, 0011 MOV, 0111 MOVI, 0000 otherwise
- alu_a, alu_b  output  WIDTH each  registered operands driven to the ALU
- alu_result  input  WIDTH  combinational ALU result
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result_lo  output  WIDTH  ALU result / product low word / quotient
- result_hi  output  WIDTH  0 for ALU ops / product high word / remainder
- illegal  output  1  op was undefined; valid with out_valid

Behaviour:
- Reset (rst_n=0 at a clk edge) from any state forces IDLE. In-flight work is discarded.
- Reset values: in_ready=1 once rst_n=1, out_valid=0, illegal=0, alu_control=0000, alu_a=alu_b=result_lo=result_hi=0, counter=0.
- States: IDLE, EXEC, MULDIV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at edge k, latch operands and decode.
  - ADD/SUB/MOV/MOVI go to EXEC.
  - MULT/DIV go to MULDIV with counter=0.
  - Illegal ops go directly to DONE with result 0 and illegal=1.
- EXEC:
  - alu_control is driven with the decoded code; alu_a/alu_b hold the latched operands.
  - At edge k+1: result_lo<=alu_result, result_hi<=0, state DONE.
  - ADD/SUB/MOV/MOVI latency: out_valid high after edge k+1.
- MULDIV:
  - One bit per cycle, unsigned.
  - MULT: 2*WIDTH-bit shift-add; the product splits into {result_hi, result_lo}.
  - DIV: restoring division; quotient goes to result_lo, remainder to result_hi.
  - Counter increments every edge. At the edge where it reaches WIDTH-1 the final iteration completes and the state goes to DONE.
  - MULT/DIV latency: out_valid high after edge k+WIDTH.
  - alu_control=0000 throughout.
- DONE:
  - out_valid=1, in_ready=0; results and illegal are held stable.
  - On out_ready at an edge: out_valid<=0, state IDLE.
  - No same-cycle new acceptance; in_ready returns the cycle after the handoff.
- in_ready is 0 in EXEC/MULDIV/DONE. in_valid is ignored there, and operand changes have no effect.
- Divide by zero follows the Optional Feature rules.
- Arithmetic is modulo 2^WIDTH for ADD/SUB, with no overflow flag.

Optional Feature:
- Macro: ALU_SEQ_DIV0_FLAG_EN.
- Defined:
  - Adds output div0 (1 bit), valid with out_valid.
  - DIV with op_b=0 skips MULDIV and goes IDLE to DONE in one cycle.
  - Outputs: div0=1, result_lo=0, result_hi=op_a, illegal=0.
- Not defined:
  - No div0 port.
  - DIV by 0 runs the full WIDTH cycles and produces result_lo=all ones, result_hi=op_a (natural restoring result).

Test Plan:
- ADD: alu_op=10, funct=100000, a=5, b=7, ALU model returns a+b -> alu_control=0010 during EXEC; out_valid after edge k+1; result_lo=12, result_hi=0.
- MULT: a=0x00010000, b=0x00010003 -> out_valid after exactly 32 cycles; result_hi=0x00000001, result_lo=0x00030000.
- DIV: a=100, b=7 -> result_lo=14, result_hi=2, 32-cycle latency. DIV: a=0xFFFFFFFF, b=1 -> result_lo=0xFFFFFFFF, result_hi=0.
- Backpressure and illegal op:
  - Hold out_ready=0 for 3 cycles after out_valid -> result stable, in_ready=0, a second in_valid ignored.
  - Then out_ready=1 -> IDLE, in_ready=1 next cycle.
  - alu_op=10, funct=111111 -> illegal=1, result_lo=0, alu_control never leaves 0000.
- Reset: rst_n=0 at cycle 10 of a MULT -> after that edge out_valid=0, in_ready=1, result_lo=result_hi=0; a following ADD 1+1 gives 2.
- DIV a=9, b=0:
  - With ALU_SEQ_DIV0_FLAG_EN: div0=1, result_hi=9, out_valid after edge k+1.
  - Without: result_lo=0xFFFFFFFF, result_hi=9, out_valid after edge k+32.
